pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 The block SHALL have parameter INC, default 2, sequential increment in bytes.
REQ-003 The block SHALL have parameter OFF_W, default 8, signed branch-offset width.
REQ-004 The block SHALL have parameter RESET_VEC, default 16'h0000, PC value after reset.
REQ-005 The block SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two).
REQ-006 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port stall, input, 1, hold PC and all state this cycle.
REQ-009 The block SHALL have port br_take, input, 1, take relative branch.
REQ-010 The block SHALL have port br_off, input, OFF_W, signed branch offset in instruction units.
REQ-011 The block SHALL have port jmp, input, 1, absolute jump.
REQ-012 The block SHALL have port jmp_addr, input, PC_W, absolute target.
REQ-013 The block SHALL have port call, input, 1, push return address (qualifies jmp).
REQ-014 The block SHALL have port ret, input, 1, pop return address into PC.
REQ-015 The block SHALL have ports halt and resume, input, 1 each, enter and leave HALT.
REQ-016 The block SHALL have port pc, output, PC_W, registered current PC.
REQ-017 The block SHALL have port pc_next, output, PC_W, combinational value pc takes at next edge.
REQ-018 The block SHALL have ports halted and ras_err, output, 1 each, HALT state flag and one-cycle stack error pulse.

Function
REQ-019 FSM states SHALL be RUN and HALT. RUN->HALT on halt. HALT->RUN on resume. halt wins over resume in RUN. stall does not block state transitions.
REQ-020 In RUN with stall=0, the next PC SHALL be selected in this priority: jmp (jmp_addr), ret with stack non-empty (top entry), br_take (pc+INC+sext(br_off)*INC), else pc+INC.
REQ-021 pc SHALL hold when stall=1, in HALT, and in the cycle halt is sampled. pc_next SHALL equal pc in those cases.
REQ-022 All PC arithmetic SHALL be modulo 2^PC_W. Wrap-around from all-ones+INC SHALL give INC-1 with no flag.
REQ-023 call with jmp SHALL push pc+INC and load jmp_addr in the same cycle. call without jmp SHALL be ignored.
REQ-024 Push when full SHALL drop the push, leave the stack unchanged and pulse ras_err. Pop when empty SHALL pulse ras_err and fall through to the br_take/increment choice.
REQ-025 call and ret together SHALL act as jmp with no push and no pop, leaving the stack depth unchanged.
REQ-026 With stall=1 or in HALT, call, ret and ras_err SHALL have no effect; ras_err SHALL be 0.

Reset
REQ-027 While rst_n=0: pc=RESET_VEC, state=RUN, halted=0, ras_err=0, stack empty. Reset asserted mid-operation SHALL discard the stack and any pending halt immediately, independent of clk.

Configuration
REQ-028 With PC_UNIT_RAS_EN defined, the stack SHALL be instantiated per REQ-023..REQ-025.
REQ-029 Without PC_UNIT_RAS_EN: call SHALL be ignored (jmp behaves plainly), ret SHALL be ignored, and ras_err SHALL be tied 0.

Structure
REQ-030 A shared package pc_pkg SHALL hold the RUN/HALT state enum and the default PC_W/INC constants.
REQ-031 The stack SHALL be sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-032 Reset release with no controls -> pc 0,2,4,6 on successive edges.
REQ-033 pc=16'h0010, br_take=1, br_off=8'hFE -> pc=16'h000E. Same cycle with jmp=1, jmp_addr=16'h0100 -> pc=16'h0100.
REQ-034 pc=16'hFFFE, no controls -> pc=16'h0000. With stall=1 -> pc stays 16'hFFFE and pc_next=16'hFFFE.
REQ-035 Five calls from pc=16'h0020 (jmp_addr=16'h0040 each), RAS_DEPTH=4 -> fifth call raises ras_err for one cycle. Four rets -> pc returns 16'h0042,16'h0042,16'h0042,16'h0022. Fifth ret -> ras_err=1 and pc increments.
REQ-036 halt at pc=16'h0008 -> halted=1 next cycle, pc frozen at 16'h0008. resume -> pc=16'h000A one edge after halted falls.
REQ-037 rst_n asserted mid-HALT with stack non-empty -> pc=RESET_VEC, halted=0 immediately. Subsequent ret -> ras_err=1.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state type and default PC geometry for the PC unit
package pc_pkg;
  typedef enum logic {RUN, HALT} state_t;
  localparam int PC_W_DEF = 16;
  localparam int INC_DEF = 2;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack (power-of-two depth); overflowing push and empty pop are ignored
module pc_ras #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt[AW];
  assign top = mem[AW'(cnt - 1'b1)];
  // occupancy count; reset discards the whole stack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (push && !full) cnt <= cnt + 1'b1;
    else if (pop && !empty) cnt <= cnt - 1'b1;
  // entry storage, written at the current count when a push is accepted
  always_ff @(posedge clk)
    if (push && !full) mem[cnt[AW-1:0]] <= din;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/halt control; return-address stack enabled by PC_UNIT_RAS_EN
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INC = INC_DEF,
  parameter int OFF_W = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_take,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jmp,
  input  logic [PC_W-1:0]  jmp_addr,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_next,
  output logic             halted,
  output logic             ras_err
);
  state_t state, nstate;
  logic active, ras_jmp, use_top;
  logic [PC_W-1:0] seq, br_tgt, top;
  assign active = state == RUN && !halt && !stall;
  assign seq = pc + PC_W'(INC);
  assign br_tgt = seq + {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off} * PC_W'(INC);
  assign halted = state == HALT;
`ifdef PC_UNIT_RAS_EN
  logic push_req, pop_req, empty, full;
  assign ras_jmp = active && call && ret;
  assign push_req = active && jmp && call && !ret;
  assign pop_req = active && ret && !call && !jmp;
  assign use_top = pop_req && !empty;
  assign ras_err = rst_n && ((push_req && full) || (pop_req && empty));
  pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push_req), .pop(use_top),
    .din(seq), .top(top), .empty(empty), .full(full)
  );
`else
  logic unused_ras;
  assign unused_ras = call ^ ret;
  assign ras_jmp = 1'b0;
  assign use_top = 1'b0;
  assign top = '0;
  assign ras_err = 1'b0;
`endif
  // next-PC select: hold unless running unstalled, then jump > return > branch > increment
  always_comb
    pc_next = !active ? pc : (jmp || ras_jmp) ? jmp_addr : use_top ? top : br_take ? br_tgt : seq;
  // RUN/HALT transitions; halt wins over resume, stall does not block them
  always_comb
    nstate = state == RUN ? (halt ? HALT : RUN) : (resume ? RUN : HALT);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= nstate;
  // PC register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_VEC;
    else pc <= pc_next;
endmodule
